// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 device-to-host frame receiver.
package ps2_pkg;

  localparam int FRAME_BITS = 11;

  // Bit positions inside the assembled frame (index 0 is the first bit on the wire)
  localparam int START_POS = 0;
  localparam int PAR_POS   = 9;
  localparam int STOP_POS  = 10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ps2_state_e;

  // Extracts d7..d0 from an assembled frame (d0 sits just after the start bit)
  function automatic logic [7:0] frame_data(input logic [FRAME_BITS-1:0] frame);
    return frame[PAR_POS-1:START_POS+1];
  endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Input conditioning for the PS/2 pins: synchronisers on both pins, a
// consecutive-sample glitch filter on ps2_clk and a falling-edge pulse.
module ps2_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_s;
  logic                   filt_q, filt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   fall_q, fall_d;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = fall_q;

  // Next-state: shift the synchronisers, count disagreeing samples, flag a filtered 1->0
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    filt_d      = filt_q;
    cnt_d       = '0;
    if (clk_s != filt_q) begin
      // The filtered level flips on the FILTER_LEN-th consecutive disagreeing sample;
      // any agreeing sample in between restarts the count.
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = clk_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  // State registers; an idle PS/2 bus sits high, so synchronisers and filter reset high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      fall_q      <= fall_d;
    end
  end

endmodule

// File: rtl/ps2_frame_receiver.sv
// Deserialises one 11-bit PS/2 device-to-host frame and presents scan code,
// framing bits and parity bit with a one-cycle frame_valid strobe.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for the start-bit falling edge
//  ST_SHIFT | collecting bits 1..10, watching the inter-edge timeout
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic [1:0] comm_init_bits,
  output logic       parity_bit,
  output logic       frame_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  logic                  fall;
  logic                  data_s;

  ps2_state_e            state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] frame_w;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [7:0]            scan_q, scan_d;
  logic [1:0]            init_q, init_d;
  logic                  par_q, par_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  ps2_input_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_input_filter (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall),
    .data_s   (data_s)
  );

  // Next-state and output-register logic for the frame FSM
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tmo_d     = tmo_q;
    scan_d    = scan_q;
    init_d    = init_q;
    par_d     = par_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    // Bits enter at the top and move down, so after 11 samples the first bit is at index 0
    frame_w   = {data_s, shift_q[FRAME_BITS-1:1]};

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (fall) begin
          shift_d   = {data_s, {(FRAME_BITS-1){1'b0}}};
          bit_cnt_d = 4'd1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A fall coinciding with timeout expiry wins: it is tested first
        if (fall) begin
          tmo_d     = '0;
          shift_d   = frame_w;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(STOP_POS)) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
            scan_d    = frame_data(frame_w);
            init_d    = {frame_w[START_POS], ~frame_w[STOP_POS]};
            par_d     = frame_w[PAR_POS];
            valid_d   = 1'b1;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          shift_d   = '0;
          tmo_d     = '0;
          err_d     = 1'b1;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any partial frame without a strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_q     <= '0;
      scan_q    <= 8'h00;
      init_q    <= 2'b11;
      par_q     <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
      scan_q    <= scan_d;
      init_q    <= init_d;
      par_q     <= par_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign scan_code      = scan_q;
  assign comm_init_bits = init_q;
  assign parity_bit     = par_q;
  assign frame_valid    = valid_q;
  assign frame_error    = err_q;
  assign busy           = (state_q == ST_SHIFT);

endmodule
